// File: rtl/vga_pkg.sv
// Shared VGA-side types and defaults for the sprite compositor.
package vga_pkg;

  localparam int VGA_XW    = 12;   // coordinate width
  localparam int VGA_CW    = 4;    // bits per colour channel
  localparam int VGA_H_RES = 640;
  localparam int VGA_V_RES = 480;

  typedef logic [VGA_XW-1:0] coord_t;

  typedef struct packed {
    logic [VGA_CW-1:0] r;
    logic [VGA_CW-1:0] g;
    logic [VGA_CW-1:0] b;
  } rgb_t;

endpackage

// File: rtl/sprite_compositor_if.sv
// Pixel-timing inputs and DAC outputs of the sprite compositor.
// master = timing generator side, slave = compositor side.
interface sprite_compositor_if #(
  parameter int N_SPR = 3,
  parameter int CW    = 4
);
  logic             i_pix_stb;
  logic             i_animate;
  logic             i_active;
  logic [9:0]       i_x;
  logic [8:0]       i_y;
  logic [N_SPR-1:0] i_spr_en;
  logic [CW-1:0]    o_r;
  logic [CW-1:0]    o_g;
  logic [CW-1:0]    o_b;
  logic [N_SPR-1:0] o_collide;

  modport master (
    output i_pix_stb, i_animate, i_active, i_x, i_y, i_spr_en,
    input  o_r, o_g, o_b, o_collide
  );

  modport slave (
    input  i_pix_stb, i_animate, i_active, i_x, i_y, i_spr_en,
    output o_r, o_g, o_b, o_collide
  );
endinterface

// File: rtl/sprite_mover.sv
// One bouncing sprite: holds centre position and direction, steps on i_move,
// and exports its bounding box as signed bounds wide enough to never wrap.
module sprite_mover
  import vga_pkg::*;
#(
  parameter int            XW    = VGA_XW,
  parameter int            H_RES = VGA_H_RES,
  parameter int            V_RES = VGA_V_RES,
  parameter int            STEP  = 1,
  parameter logic [XW-1:0] IX    = '0,
  parameter logic [XW-1:0] IY    = '0,
  parameter logic [XW-1:0] HS    = '0,
  parameter logic          DX    = 1'b1,
  parameter logic          DY    = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_move,
  output logic signed [XW+1:0] o_x1,
  output logic signed [XW+1:0] o_x2,
  output logic signed [XW+1:0] o_y1,
  output logic signed [XW+1:0] o_y2
);

  // Two spare bits: one for the sign, one so centre + half-size never overflows.
  typedef logic signed [XW+1:0] sw_t;

  localparam sw_t LO     = sw_t'({2'b00, HS});
  localparam sw_t STEP_S = sw_t'(STEP);
  localparam sw_t X_HI   = sw_t'(H_RES - 1) - LO;
  localparam sw_t Y_HI   = sw_t'(V_RES - 1) - LO;

  logic [XW-1:0] x_q, x_d, y_q, y_d;
  logic          dx_q, dx_d, dy_q, dy_d;

  // One axis step: returns {dir, pos}. Low edge is tested first, so a sprite
  // larger than the screen pins to its half-size instead of wrapping.
  function automatic logic [XW:0] step_axis(input logic [XW-1:0] pos,
                                            input logic          dir,
                                            input sw_t           hi);
    sw_t nxt;
    nxt = sw_t'({2'b00, pos}) + (dir ? STEP_S : -STEP_S);
    if (nxt <= LO)      return {1'b1, HS};
    else if (nxt >= hi) return {1'b0, hi[XW-1:0]};
    else                return {dir, nxt[XW-1:0]};
  endfunction

  // Next position/direction, applied only when a move is requested.
  always_comb begin
    {dx_d, x_d} = step_axis(x_q, dx_q, X_HI);
    {dy_d, y_d} = step_axis(y_q, dy_q, Y_HI);
  end

  // Position and direction state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      x_q  <= IX;
      y_q  <= IY;
      dx_q <= DX;
      dy_q <= DY;
    end else if (i_move) begin
      x_q  <= x_d;
      y_q  <= y_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

  assign o_x1 = sw_t'({2'b00, x_q}) - LO;
  assign o_x2 = sw_t'({2'b00, x_q}) + LO;
  assign o_y1 = sw_t'({2'b00, y_q}) - LO;
  assign o_y2 = sw_t'({2'b00, y_q}) + LO;

endmodule

// File: rtl/sprite_compositor.sv
// N-channel bouncing-rectangle compositor between VGA timing and the DAC.
// Sprite 0 has the highest priority. Optional feature macro SPRITE_COLLIDE_EN
// builds the per-frame collision mask; without it o_collide is tied low.
module sprite_compositor
  import vga_pkg::*;
#(
  parameter int                     N_SPR = 3,
  parameter int                     CW    = VGA_CW,
  parameter int                     XW    = VGA_XW,
  parameter int                     H_RES = VGA_H_RES,
  parameter int                     V_RES = VGA_V_RES,
  parameter int                     STEP  = 1,
  parameter logic [N_SPR*XW-1:0]    P_IX  = {12'd480, 12'd320, 12'd160},
  parameter logic [N_SPR*XW-1:0]    P_IY  = {12'd360, 12'd240, 12'd120},
  parameter logic [N_SPR*XW-1:0]    P_HS  = {12'd100, 12'd40,  12'd60},
  parameter logic [N_SPR-1:0]       P_DX  = 3'b111,
  parameter logic [N_SPR-1:0]       P_DY  = 3'b101,
  parameter logic [N_SPR*3*CW-1:0]  P_COL = {12'h00F, 12'h0F0, 12'hF00}
) (
  input  logic                i_clk,
  input  logic                i_rst,
  sprite_compositor_if.slave  bus
);

  typedef logic signed [XW+1:0] sw_t;

  logic             move;
  logic [N_SPR-1:0] hit;
  sw_t              px, py;
  sw_t              x1_w [N_SPR];
  sw_t              x2_w [N_SPR];
  sw_t              y1_w [N_SPR];
  sw_t              y2_w [N_SPR];
  logic [3*CW-1:0]  col_d, col_q;

  assign move = bus.i_pix_stb & bus.i_animate;
  assign px   = sw_t'(bus.i_x);
  assign py   = sw_t'(bus.i_y);

  // Per-sprite motion state plus the strict-inequality hit test.
  for (genvar k = 0; k < N_SPR; k++) begin : g_spr
    sprite_mover #(
      .XW   (XW),
      .H_RES(H_RES),
      .V_RES(V_RES),
      .STEP (STEP),
      .IX   (P_IX[k*XW +: XW]),
      .IY   (P_IY[k*XW +: XW]),
      .HS   (P_HS[k*XW +: XW]),
      .DX   (P_DX[k]),
      .DY   (P_DY[k])
    ) u_mov (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_move(move & bus.i_spr_en[k]),
      .o_x1  (x1_w[k]),
      .o_x2  (x2_w[k]),
      .o_y1  (y1_w[k]),
      .o_y2  (y2_w[k])
    );

    assign hit[k] = bus.i_spr_en[k] &&
                    (x1_w[k] < px) && (px < x2_w[k]) &&
                    (y1_w[k] < py) && (py < y2_w[k]);
  end

  // Priority mux: scan high index to low so the lowest hit index wins; blank outside the visible area.
  always_comb begin
    col_d = '0;
    for (int k = N_SPR - 1; k >= 0; k--) begin
      if (hit[k]) col_d = P_COL[k*3*CW +: 3*CW];
    end
    if (!bus.i_active) col_d = '0;
  end

  // Output colour register, advanced only on the pixel strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst)              col_q <= '0;
    else if (bus.i_pix_stb) col_q <= col_d;
  end

  assign bus.o_r = col_q[3*CW-1 -: CW];
  assign bus.o_g = col_q[2*CW-1 -: CW];
  assign bus.o_b = col_q[CW-1   -: CW];

`ifdef SPRITE_COLLIDE_EN
  logic [N_SPR-1:0] mask_q, coll_q, pix_coll;
  logic             multi;

  // Two or more simultaneous hits: clearing the lowest set bit leaves something.
  assign multi    = (hit & (hit - 1'b1)) != '0;
  assign pix_coll = (bus.i_active && multi) ? hit : '0;

  // Sticky per-frame mask, published and cleared on the end-of-frame strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mask_q <= '0;
      coll_q <= '0;
    end else if (bus.i_pix_stb) begin
      if (bus.i_animate) begin
        coll_q <= mask_q | pix_coll;
        mask_q <= '0;
      end else begin
        mask_q <= mask_q | pix_coll;
      end
    end
  end

  assign bus.o_collide = coll_q;
`else
  assign bus.o_collide = '0;
`endif

endmodule
